// File: rtl/cmp_stim_checker.sv
// cmp_stim_checker
//
// Built-in stimulus engine and checker for a WIDTH-bit unsigned greater-than
// comparator. On start it walks every operand pair (a-major, b-minor, from 0
// upward). Each pair is held for SETTLE cycles and then sampled for one cycle.
// A sampled res that differs from a>b is counted, and the first failing pair
// is captured.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous reset, active-high
//   start      begins a sweep; accepted only when idle or done
//   a, b       operands driven to the comparator under test
//   res        comparator result; expected value is a > b (unsigned)
//   busy       high while a sweep is in progress
//   done       high once the sweep completes; held until start or rst
//   err_cnt    number of mismatching pairs in the last or current sweep
//   fail_seen  set on the first mismatch of a sweep
//   first_a    operand a of the first mismatching pair
//   first_b    operand b of the first mismatching pair
module cmp_stim_checker #(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    input  logic               res,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   err_cnt,
    output logic               fail_seen,
    output logic [WIDTH-1:0]   first_a,
    output logic [WIDTH-1:0]   first_b
);

    localparam int IW = 2 * WIDTH;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [IW-1:0] IDX_ONE    = 1;
    localparam logic [IW:0]   ERR_ONE    = 1;
    localparam logic [CW-1:0] CNT_ONE    = 1;
    localparam logic [CW-1:0] SETTLE_TOP = CW'(SETTLE - 1);

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] settle_cnt;
    logic          mismatch;
    logic          last_pair;

    // Operands are fields of the registered pair index, so they are
    // registered outputs and track idx without extra storage.
    assign a = idx[IW-1:WIDTH];
    assign b = idx[WIDTH-1:0];

    assign mismatch  = (res != (a > b));
    // Terminal pair is detected explicitly so idx never wraps.
    assign last_pair = &idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_cnt    <= '0;
            fail_seen  <= 1'b0;
            first_a    <= '0;
            first_b    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_DRIVE;
                        idx        <= '0;
                        settle_cnt <= SETTLE_TOP;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err_cnt    <= '0;
                        fail_seen  <= 1'b0;
                        first_a    <= '0;
                        first_b    <= '0;
                    end
                end

                // Hold the pair for SETTLE cycles (counter SETTLE-1 down to 0).
                ST_DRIVE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_ONE;
                    end
                end

                ST_SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + ERR_ONE;
                        if (!fail_seen) begin
                            fail_seen <= 1'b1;
                            first_a   <= a;
                            first_b   <= b;
                        end
                    end
                    if (last_pair) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx        <= idx + IDX_ONE;
                        settle_cnt <= SETTLE_TOP;
                        state      <= ST_DRIVE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_stim_checker.sv
module tb_cmp_stim_checker;

    logic clk;
    logic rst;
    logic start;
    logic sel;          // 0: SETTLE=1 instance, 1: SETTLE=3 instance
    int   mode;         // comparator behaviour seen by the checker
    logic [63:0] flip;  // per-pair fault mask for the random comparator mode

    int n_checks;
    int n_errors;

    logic       start0, start1;
    logic [2:0] a0, b0, a1, b1, fa0, fb0, fa1, fb1;
    logic       res0, res1, busy0, busy1, done0, done1, fs0, fs1;
    logic [6:0] err0, err1;

    logic [2:0] cur_a, cur_b, cur_fa, cur_fb;
    logic       cur_busy, cur_done, cur_fs;
    logic [6:0] cur_err;

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    cmp_stim_checker #(.WIDTH(3), .SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .res(res0),
        .busy(busy0), .done(done0), .err_cnt(err0), .fail_seen(fs0),
        .first_a(fa0), .first_b(fb0)
    );

    cmp_stim_checker #(.WIDTH(3), .SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .res(res1),
        .busy(busy1), .done(done1), .err_cnt(err1), .fail_seen(fs1),
        .first_a(fa1), .first_b(fb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator attached to each checker.
    function automatic logic cmp_res(input int m, input logic [2:0] x, input logic [2:0] y);
        logic gt;
        gt = (x > y);
        case (m)
            0:       return gt;
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~gt;
            default: return gt ^ flip[{x, y}];
        endcase
    endfunction

    always_comb res0 = cmp_res(mode, a0, b0);
    always_comb res1 = cmp_res(mode, a1, b1);

    always_comb begin
        cur_a    = sel ? a1    : a0;
        cur_b    = sel ? b1    : b0;
        cur_busy = sel ? busy1 : busy0;
        cur_done = sel ? done1 : done0;
        cur_err  = sel ? err1  : err0;
        cur_fs   = sel ? fs1   : fs0;
        cur_fa   = sel ? fa1   : fa0;
        cur_fb   = sel ? fb1   : fb0;
    end

    // Reference: enumerate all 64 pairs in sweep order and score them.
    function automatic void model(input int m, output int e, output int fa,
                                  output int fb, output bit fs);
        e = 0; fa = 0; fb = 0; fs = 1'b0;
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                bit gt;
                bit r;
                gt = (x > y);
                case (m)
                    0:       r = gt;
                    1:       r = 1'b0;
                    2:       r = 1'b1;
                    3:       r = !gt;
                    default: r = gt ^ flip[x*8 + y];
                endcase
                if (r != gt) begin
                    e++;
                    if (!fs) begin
                        fs = 1'b1; fa = x; fb = y;
                    end
                end
            end
        end
    endfunction

    task automatic run_sweep(input string name, input int s, input int m, input int pulse_at);
        int e, fa, fb, cyc, total, bad_cyc;
        bit fs, seq_ok;
        model(m, e, fa, fb, fs);
        sel   = (s == 3);
        mode  = m;
        total = 64 * (s + 1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        n_checks++;
        if (!(cur_busy === 1'b1 && cur_done === 1'b0 && cur_err === 7'd0 &&
              cur_fs === 1'b0 && cur_fa === 3'd0 && cur_fb === 3'd0)) begin
            n_errors++;
            $display("FAIL %s_launch: busy=%b done=%b err=%0d fs=%b first=%0d/%0d, required busy=1 done=0 err=0 fs=0 first=0/0",
                     name, cur_busy, cur_done, cur_err, cur_fs, cur_fa, cur_fb);
        end

        cyc = 0; seq_ok = 1'b1; bad_cyc = 0;
        while (cur_done !== 1'b1 && cyc < total + 20) begin
            if (cur_busy !== 1'b1 || {cur_a, cur_b} !== 6'(cyc / (s + 1))) begin
                if (seq_ok) bad_cyc = cyc;
                seq_ok = 1'b0;
            end
            start = (cyc == pulse_at);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;

        n_checks++;
        if (!seq_ok) begin
            n_errors++;
            $display("FAIL %s_sequence: pair order or busy wrong at cycle %0d, required pair %0d with busy=1",
                     name, bad_cyc, bad_cyc / (s + 1));
        end
        n_checks++;
        if (cyc != total) begin
            n_errors++;
            $display("FAIL %s_latency: done after %0d cycles, required %0d", name, cyc, total);
        end
        n_checks++;
        if (cur_done !== 1'b1 || cur_busy !== 1'b0 || {cur_a, cur_b} !== 6'h3f) begin
            n_errors++;
            $display("FAIL %s_done_state: done=%b busy=%b a/b=%0d/%0d, required done=1 busy=0 a/b=7/7",
                     name, cur_done, cur_busy, cur_a, cur_b);
        end
        n_checks++;
        if (cur_err !== 7'(e) || cur_fs !== fs || cur_fa !== 3'(fa) || cur_fb !== 3'(fb)) begin
            n_errors++;
            $display("FAIL %s_result: err=%0d fs=%b first=%0d/%0d, required err=%0d fs=%b first=%0d/%0d",
                     name, cur_err, cur_fs, cur_fa, cur_fb, e, fs, fa, fb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({a0, b0, busy0, done0, err0, fs0, fa0, fb0} !== '0 ||
            {a1, b1, busy1, done1, err1, fs1, fa1, fb1} !== '0) begin
            n_errors++;
            $display("FAIL reset_values: s1=%h s3=%h, required all zero",
                     {a0, b0, busy0, done0, err0, fs0, fa0, fb0},
                     {a1, b1, busy1, done1, err1, fs1, fa1, fb1});
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0 || {a0, b0} !== 6'd0) begin
            n_errors++;
            $display("FAIL reset_idle: busy0=%b busy1=%b done0=%b a/b=%0d/%0d, required idle zeros",
                     busy0, busy1, done0, a0, b0);
        end
    endtask

    task automatic test_correct();
        run_sweep("correct_s1", 1, 0, -1);
    endtask

    task automatic test_stuck_low();
        run_sweep("stuck0", 1, 1, -1);
        n_checks++;
        if (cur_err !== 7'd28 || cur_fs !== 1'b1 || cur_fa !== 3'd1 || cur_fb !== 3'd0) begin
            n_errors++;
            $display("FAIL stuck0_fixed: err=%0d fs=%b first=%0d/%0d, required 28 1 1/0",
                     cur_err, cur_fs, cur_fa, cur_fb);
        end
    endtask

    task automatic test_stuck_high();
        run_sweep("stuck1", 1, 2, -1);
        n_checks++;
        if (cur_err !== 7'd36 || cur_fa !== 3'd0 || cur_fb !== 3'd0) begin
            n_errors++;
            $display("FAIL stuck1_fixed: err=%0d first=%0d/%0d, required 36 0/0",
                     cur_err, cur_fa, cur_fb);
        end
    endtask

    task automatic test_inverted_restart();
        run_sweep("inverted", 1, 3, -1);
        run_sweep("inverted_again", 1, 3, -1);
        n_checks++;
        if (cur_err !== 7'd64 || cur_fs !== 1'b1) begin
            n_errors++;
            $display("FAIL inverted_max: err=%0d fs=%b, required 64 1", cur_err, cur_fs);
        end
    endtask

    task automatic test_busy_start();
        run_sweep("settle3_busy_start", 3, 0, 50);
        n_checks++;
        if (cur_err !== 7'd0 || cur_fs !== 1'b0) begin
            n_errors++;
            $display("FAIL settle3_clean: err=%0d fs=%b, required 0 0", cur_err, cur_fs);
        end
    endtask

    task automatic test_mid_reset();
        sel = 1'b0; mode = 1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({a0, b0, busy0, done0, err0, fs0, fa0, fb0} !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_clear: outputs=%h, required all zero",
                     {a0, b0, busy0, done0, err0, fs0, fa0, fb0});
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy0 !== 1'b0 || {a0, b0} !== 6'd0) begin
            n_errors++;
            $display("FAIL mid_reset_idle: busy=%b a/b=%0d/%0d, required 0 0/0", busy0, a0, b0);
        end
        run_sweep("after_reset", 1, 1, -1);
        n_checks++;
        if (cur_err !== 7'd28) begin
            n_errors++;
            $display("FAIL after_reset_count: err=%0d, required 28", cur_err);
        end
    endtask

    task automatic test_random_faults();
        for (int i = 0; i < 4; i++) begin
            flip = {$urandom, $urandom};
            if (i == 3) flip = flip & {$urandom, $urandom} & {$urandom, $urandom};
            run_sweep($sformatf("random%0d", i), (i % 2 == 0) ? 1 : 3, 4, -1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        sel   = 1'b0;
        mode  = 0;
        flip  = '0;
        start = 1'b0;
        rst   = 1'b1;
        test_reset();
        test_correct();
        test_stuck_low();
        test_stuck_high();
        test_inverted_restart();
        test_busy_start();
        test_mid_reset();
        test_random_faults();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
